// File: rtl/sar_conv_sequencer.sv
// Initiator-side sequencer for the 7-bit SAR engine: pulses soc, waits for eoc,
// averages 2^AVG_LOG2 conversions and hands each averaged sample downstream.
module sar_conv_sequencer #(
  parameter int AVG_LOG2 = 2,
  parameter int SOC_HOLD = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       soc,
  input  logic       eoc,
  input  logic [6:0] adc_q,
  output logic [6:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       timeout_err,
  output logic       overrun,
  input  logic       clear_err
);

  localparam int AW = 7 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int HW = $clog2(SOC_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] AVG_N     = CW'(1 << AVG_LOG2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SOC_HOLD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_EOC, CAPTURE, DELIVER} state_t;

  state_t        state, next_state;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] to_cnt;
  logic [AW-1:0] acc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;
  logic          timeout_hit;
  logic          capture_hit;
  logic          deliver_hit;

  assign count_inc = count + CW'(1);

  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    capture_hit = 1'b0;
    deliver_hit = 1'b0;
    case (state)
      IDLE:     if (enable) next_state = START;
      START:    if (hold_cnt == HOLD_LAST) next_state = WAIT_EOC;
      WAIT_EOC: begin
        if (eoc) begin
          next_state = CAPTURE;
        end else if (to_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          next_state  = START;
        end
      end
      CAPTURE: begin
        capture_hit = 1'b1;
        next_state  = (count_inc == AVG_N) ? DELIVER : START;
      end
      DELIVER: begin
        deliver_hit = 1'b1;
        next_state  = START;
      end
      default:  next_state = IDLE;
    endcase
    // Dropping enable parks the engine; a delivery already underway still lands.
    if (!enable && state != IDLE) begin
      next_state  = IDLE;
      timeout_hit = 1'b0;
      capture_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      soc      <= 1'b1;
      hold_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= next_state;
      soc      <= (next_state == IDLE) || (next_state == START);
      hold_cnt <= (state == START && next_state == START) ? hold_cnt + HW'(1) : '0;
      to_cnt   <= (state == WAIT_EOC && next_state == WAIT_EOC) ? to_cnt + TW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
    end else if (deliver_hit || next_state == IDLE) begin
      acc   <= '0;
      count <= '0;
    end else if (capture_hit) begin
      acc   <= acc + AW'(adc_q);
      count <= count_inc;
    end
  end

  // Handshake runs independently of the FSM; a set event beats clear_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data        <= '0;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (deliver_hit) begin
        data       <= acc[AW-1:AVG_LOG2];
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      overrun     <= (deliver_hit && data_valid && !data_ready) || (overrun && !clear_err);
      timeout_err <= timeout_hit || (timeout_err && !clear_err);
    end
  end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Bench for sar_conv_sequencer: one averaging instance (AVG_LOG2=2) and one
// pass-through instance (AVG_LOG2=0), each fed by a behavioural SAR engine.
module tb_sar_conv_sequencer;

  logic       clk;
  logic       rst_n;
  logic       clear_err;
  logic       data_ready;
  logic [1:0] enable;
  logic [1:0] soc;
  logic [1:0] eoc;
  logic [1:0] data_valid;
  logic [1:0] timeout_err;
  logic [1:0] overrun;
  logic [6:0] adc_q [2];
  logic [6:0] data [2];

  int checks = 0;
  int failures = 0;

  // SAR engine model state; index 0 feeds the averaging instance.
  int fixed_lat;
  bit rand_lat;
  bit sar_dead;
  int act;
  int low_cnt [2];
  bit done [2];
  int rlat [2];
  int fq[$];
  int fq_rd;
  int exp_q[$];
  int exp_rd;
  int gsum;
  int gn;
  int v;

  typedef struct {
    int         dut;
    logic [6:0] v0;
    logic [6:0] v1;
    logic [6:0] v2;
    logic [6:0] v3;
    logic [6:0] expv;
  } vec_t;

  vec_t vecs [8];

  sar_conv_sequencer #(.AVG_LOG2(2), .SOC_HOLD(2), .TIMEOUT(15)) u_avg4 (
    .clk(clk), .rst_n(rst_n), .enable(enable[0]), .soc(soc[0]), .eoc(eoc[0]),
    .adc_q(adc_q[0]), .data(data[0]), .data_valid(data_valid[0]),
    .data_ready(data_ready), .timeout_err(timeout_err[0]), .overrun(overrun[0]),
    .clear_err(clear_err)
  );

  sar_conv_sequencer #(.AVG_LOG2(0), .SOC_HOLD(2), .TIMEOUT(15)) u_avg1 (
    .clk(clk), .rst_n(rst_n), .enable(enable[1]), .soc(soc[1]), .eoc(eoc[1]),
    .adc_q(adc_q[1]), .data(data[1]), .data_valid(data_valid[1]),
    .data_ready(data_ready), .timeout_err(timeout_err[1]), .overrun(overrun[1]),
    .clear_err(clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine converts while soc is low, raises eoc after a latency and holds it
  // until soc rises; the expected average is the mean of each completed group.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        eoc      <= '0;
        adc_q[0] <= '0;
        adc_q[1] <= '0;
        for (int i = 0; i < 2; i++) begin
          low_cnt[i] = 0;
          done[i]    = 1'b0;
          rlat[i]    = 3;
        end
        fq_rd = 0;
        gsum  = 0;
        gn    = 0;
        exp_q.delete();
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (soc[i]) begin
            eoc[i] <= 1'b0;
            low_cnt[i] = 0;
            done[i]    = 1'b0;
          end else if (!done[i] && !sar_dead) begin
            low_cnt[i]++;
            if (low_cnt[i] >= (rand_lat ? rlat[i] : fixed_lat)) begin
              if (fq_rd < fq.size()) begin
                v = fq[fq_rd];
                fq_rd++;
              end else begin
                v = int'($urandom_range(0, 127));
              end
              eoc[i]   <= 1'b1;
              adc_q[i] <= 7'(v);
              done[i]  = 1'b1;
              rlat[i]  = int'($urandom_range(1, 6));
              if (i == act) begin
                gsum += v;
                gn++;
                if (gn == ((act == 0) ? 4 : 1)) begin
                  exp_q.push_back(gsum / ((act == 0) ? 4 : 1));
                  gsum = 0;
                  gn   = 0;
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic do_reset(input int which);
    rst_n      = 1'b0;
    enable     = '0;
    data_ready = 1'b0;
    clear_err  = 1'b0;
    sar_dead   = 1'b0;
    rand_lat   = 1'b0;
    fixed_lat  = 3;
    act        = which;
    fq.delete();
    exp_rd = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input int d, input string name);
    int n = 0;
    while (!data_valid[d] && n < 400) begin
      tick();
      n++;
    end
    check(name, int'(data_valid[d]), 1);
  endtask

  task automatic wait_soc(input int d, input logic val, input string name);
    int n = 0;
    while (soc[d] != val && n < 400) begin
      tick();
      n++;
    end
    check(name, int'(soc[d]), int'(val));
  endtask

  task automatic wait_eoc(input int d, input logic val, input string name);
    int n = 0;
    while (eoc[d] != val && n < 400) begin
      tick();
      n++;
    end
    check(name, int'(eoc[d]), int'(val));
  endtask

  initial begin
    int d;
    int n;
    int nv;
    int ns;
    int seen;
    int got;
    int age;
    int cyc;
    int target;
    bit stable;

    rst_n      = 1'b0;
    enable     = '0;
    data_ready = 1'b0;
    clear_err  = 1'b0;
    sar_dead   = 1'b0;
    rand_lat   = 1'b0;
    fixed_lat  = 3;
    act        = 0;
    exp_rd     = 0;

    vecs[0] = '{0, 7'd10,  7'd11,  7'd12,  7'd13,  7'd11};
    vecs[1] = '{0, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127};
    vecs[2] = '{0, 7'd0,   7'd0,   7'd0,   7'd0,   7'd0};
    vecs[3] = '{0, 7'd1,   7'd1,   7'd1,   7'd2,   7'd1};
    vecs[4] = '{0, 7'd3,   7'd3,   7'd3,   7'd2,   7'd2};
    vecs[5] = '{0, 7'd100, 7'd101, 7'd102, 7'd103, 7'd101};
    vecs[6] = '{1, 7'h55,  7'd0,   7'd0,   7'd0,   7'h55};
    vecs[7] = '{1, 7'd127, 7'd0,   7'd0,   7'd0,   7'd127};

    do_reset(0);
    check("reset_soc", int'(soc), 3);
    check("reset_valid", int'(data_valid), 0);
    check("reset_data0", int'(data[0]), 0);
    check("reset_flags", int'({timeout_err, overrun}), 0);

    for (int k = 0; k < 8; k++) begin
      d = vecs[k].dut;
      do_reset(d);
      fq.push_back(int'(vecs[k].v0));
      fq.push_back(int'(vecs[k].v1));
      fq.push_back(int'(vecs[k].v2));
      fq.push_back(int'(vecs[k].v3));
      enable[d] = 1'b1;
      wait_valid(d, $sformatf("vec%0d_valid", k));
      check($sformatf("vec%0d_data", k), int'(data[d]), int'(vecs[k].expv));
    end

    // Asynchronous reset in the middle of a conversion.
    do_reset(1);
    fq.push_back(42);
    enable[1] = 1'b1;
    wait_valid(1, "t1_pre_valid");
    wait_soc(1, 1'b0, "t1_in_wait");
    tick();
    rst_n = 1'b0;
    #1;
    check("t1_async_soc", int'(soc[1]), 1);
    check("t1_async_valid", int'(data_valid[1]), 0);
    check("t1_async_data", int'(data[1]), 0);
    enable = '0;
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (data_valid[1]) seen++;
    end
    check("t1_no_sample", seen, 0);

    // Pass-through: one-cycle valid with ready high, soc held SOC_HOLD cycles.
    do_reset(1);
    data_ready = 1'b1;
    for (int j = 0; j < 3; j++) fq.push_back(32'h55);
    enable[1] = 1'b1;
    wait_valid(1, "t2_valid");
    check("t2_data", int'(data[1]), 32'h55);
    nv = 0;
    ns = 0;
    for (int j = 0; j < 6; j++) begin
      if (data_valid[1]) nv++;
      if (soc[1]) ns++;
      tick();
    end
    check("t2_valid_cycles", nv, 1);
    check("t2_soc_hold", ns, 2);

    // Averaged sample waits for ready, then drops.
    do_reset(0);
    fq.push_back(10); fq.push_back(11); fq.push_back(12); fq.push_back(13);
    enable[0] = 1'b1;
    wait_valid(0, "t3_valid");
    check("t3_data", int'(data[0]), 11);
    stable = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (!data_valid[0] || data[0] != 7'd11) stable = 1'b0;
    end
    check("t3_held", int'(stable), 1);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("t3_consumed", int'(data_valid[0]), 0);

    // Timeout with clear_err held high: setting wins, then retry succeeds.
    do_reset(0);
    sar_dead  = 1'b1;
    clear_err = 1'b1;
    enable[0] = 1'b1;
    wait_soc(0, 1'b0, "t4_in_wait");
    check("t4_err_early", int'(timeout_err[0]), 0);
    n = 0;
    while (soc[0] == 1'b0 && n < 40) begin
      n++;
      tick();
    end
    check("t4_wait_cycles", n, 15);
    check("t4_err_set", int'(timeout_err[0]), 1);
    clear_err = 1'b0;
    sar_dead  = 1'b0;
    fq.push_back(20); fq.push_back(20); fq.push_back(20); fq.push_back(24);
    wait_valid(0, "t4_retry_valid");
    check("t4_retry_data", int'(data[0]), 21);
    check("t4_sticky", int'(timeout_err[0]), 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t4_cleared", int'(timeout_err[0]), 0);

    // Overwrite of an unconsumed sample.
    do_reset(1);
    fq.push_back(32'h10); fq.push_back(32'h20);
    enable[1] = 1'b1;
    wait_valid(1, "t5_valid");
    check("t5_first", int'(data[1]), 32'h10);
    check("t5_no_ovr", int'(overrun[1]), 0);
    n = 0;
    while (data[1] == 7'h10 && n < 100) begin
      tick();
      n++;
    end
    check("t5_second", int'(data[1]), 32'h20);
    check("t5_overrun", int'(overrun[1]), 1);

    // Ready on the delivery cycle: consume and reload, no overrun.
    do_reset(1);
    fq.push_back(32'h30); fq.push_back(32'h40);
    enable[1] = 1'b1;
    wait_valid(1, "t5b_valid");
    check("t5b_first", int'(data[1]), 32'h30);
    wait_eoc(1, 1'b0, "t5b_eoc_low");
    wait_eoc(1, 1'b1, "t5b_eoc_high");
    tick();
    tick();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("t5b_valid_kept", int'(data_valid[1]), 1);
    check("t5b_data", int'(data[1]), 32'h40);
    check("t5b_no_ovr", int'(overrun[1]), 0);

    // Enable dropped mid-average discards the partial sum.
    do_reset(0);
    fq.push_back(50); fq.push_back(60);
    enable[0] = 1'b1;
    wait_eoc(0, 1'b1, "t6_conv1");
    wait_eoc(0, 1'b0, "t6_conv1_end");
    wait_eoc(0, 1'b1, "t6_conv2");
    wait_eoc(0, 1'b0, "t6_conv2_end");
    wait_soc(0, 1'b0, "t6_third_wait");
    enable[0] = 1'b0;
    tick();
    check("t6_soc_park", int'(soc[0]), 1);
    seen = 0;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (data_valid[0] || !soc[0]) seen++;
    end
    check("t6_parked", seen, 0);
    fq.push_back(4); fq.push_back(4); fq.push_back(4); fq.push_back(4);
    enable[0] = 1'b1;
    wait_valid(0, "t6_valid");
    check("t6_data", int'(data[0]), 4);

    // Random results and latencies with random ready, scored against the model.
    for (int dd = 0; dd < 2; dd++) begin
      do_reset(dd);
      rand_lat    = 1'b1;
      enable[dd]  = 1'b1;
      got    = 0;
      age    = 0;
      cyc    = 0;
      target = (dd == 0) ? 12 : 25;
      while (got < target && cyc < 5000) begin
        data_ready = ($urandom_range(0, 1) == 1) || (age >= 4);
        if (data_valid[dd]) begin
          if (data_ready) begin
            if (exp_rd < exp_q.size())
              check($sformatf("rnd%0d_s%0d", dd, got), int'(data[dd]), exp_q[exp_rd]);
            else
              check($sformatf("rnd%0d_s%0d_depth", dd, got), exp_q.size(), exp_rd + 1);
            exp_rd++;
            got++;
            age = 0;
          end else begin
            age++;
          end
        end
        tick();
        cyc++;
      end
      data_ready = 1'b0;
      check($sformatf("rnd%0d_count", dd), got, target);
      check($sformatf("rnd%0d_overrun", dd), int'(overrun[dd]), 0);
      check($sformatf("rnd%0d_timeout", dd), int'(timeout_err[dd]), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
